// File: rtl/nw_pkg.sv
// Shared types and helpers for the Needleman-Wunsch traceback emitter.
package nw_pkg;

   localparam int MATCH_W    = 1;
   localparam int INDEL_W    = -1;
   localparam int MISMATCH_W = -1;

   localparam int MAX_SW = 256;
   localparam int MAX_CW = 8;

   typedef enum logic [1:0] {
      NO_DIR     = 2'd0,
      TOP_DIR    = 2'd1,
      LEFT_DIR   = 2'd2,
      CORNER_DIR = 2'd3
   } dir_e;

   typedef enum logic [2:0] {
      S_IDLE,
      S_FIRST,
      S_RUN,
      S_FLUSH,
      S_DONE,
      S_ERR
   } state_e;

   // Character idx lives at the top of the packed string.
   function automatic logic [MAX_CW-1:0] char_at(
      input logic [MAX_SW-1:0] s,
      input int                idx,
      input int                len,
      input int                cw
   );
      logic [MAX_SW-1:0] t;
      t = s >> ((len - 1 - idx) * cw);
      return t[MAX_CW-1:0] & MAX_CW'((1 << cw) - 1);
   endfunction

endpackage

// File: rtl/nw_score_acc.sv
// Match/mismatch/gap counters and the weighted alignment score.
module nw_score_acc
   import nw_pkg::*;
#(
   parameter int CNT_W    = 9,
   parameter int SWIDTH   = 16,
   parameter int MATCH    = MATCH_W,
   parameter int INDEL    = INDEL_W,
   parameter int MISMATCH = MISMATCH_W
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     clr,
   input  logic                     inc_m,
   input  logic                     inc_mm,
   input  logic                     inc_g,
   output logic signed [SWIDTH-1:0] score
);

   logic [CNT_W-1:0] m_q, m_d;
   logic [CNT_W-1:0] mm_q, mm_d;
   logic [CNT_W-1:0] g_q, g_d;

   logic signed [SWIDTH-1:0] sm, smm, sg;

   always_comb begin
      m_d  = m_q;
      mm_d = mm_q;
      g_d  = g_q;
      if (clr) begin
         m_d  = '0;
         mm_d = '0;
         g_d  = '0;
      end else begin
         if (inc_m)  m_d  = m_q + 1'b1;
         if (inc_mm) mm_d = mm_q + 1'b1;
         if (inc_g)  g_d  = g_q + 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         m_q  <= '0;
         mm_q <= '0;
         g_q  <= '0;
      end else begin
         m_q  <= m_d;
         mm_q <= mm_d;
         g_q  <= g_d;
      end
   end

   assign sm  = SWIDTH'(m_q);
   assign smm = SWIDTH'(mm_q);
   assign sg  = SWIDTH'(g_q);

   assign score = SWIDTH'(MATCH * sm + MISMATCH * smm + INDEL * sg);

endmodule

// File: rtl/nw_align_emitter.sv
// Turns a NW traceback coordinate stream into aligned columns
// and recomputes the alignment score.
module nw_align_emitter
   import nw_pkg::*;
#(
   parameter int LENGTH      = 10,
   parameter int CWIDTH      = 2,
   parameter int SWIDTH      = 16,
   parameter int CORD_LENGTH = 8,
   parameter int MATCH       = MATCH_W,
   parameter int INDEL       = INDEL_W,
   parameter int MISMATCH    = MISMATCH_W
) (
   input  logic                       clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [LENGTH*CWIDTH-1:0]   s1,
   input  logic [LENGTH*CWIDTH-1:0]   s2,
   input  logic                       in_valid,
   output logic                       in_ready,
   input  logic [CORD_LENGTH-1:0]     in_x,
   input  logic [CORD_LENGTH-1:0]     in_y,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [CWIDTH-1:0]          out_c1,
   output logic [CWIDTH-1:0]          out_c2,
   output logic                       out_gap1,
   output logic                       out_gap2,
   output logic                       out_last,
   output logic                       done,
   output logic signed [SWIDTH-1:0]   score,
   output logic                       err
);

   localparam int SW    = LENGTH * CWIDTH;
   localparam int CNT_W = CORD_LENGTH + 1;
   localparam logic [CORD_LENGTH-1:0] LASTC = CORD_LENGTH'(LENGTH - 1);
   localparam logic [CORD_LENGTH-1:0] ONE   = CORD_LENGTH'(1);

   state_e state_q, state_d;

   logic [SW-1:0]          s1_q, s1_d;
   logic [SW-1:0]          s2_q, s2_d;
   logic [CORD_LENGTH-1:0] px_q, px_d;
   logic [CORD_LENGTH-1:0] py_q, py_d;
   logic                   ov_q, ov_d;
   logic [CWIDTH-1:0]      c1_q, c1_d;
   logic [CWIDTH-1:0]      c2_q, c2_d;
   logic                   g1_q, g1_d;
   logic                   g2_q, g2_d;
   logic                   last_q, last_d;

   logic                   accept;
   logic                   clr, inc_m, inc_mm, inc_g;
   logic [CWIDTH-1:0]      p1, p2, f1, f2;
   logic [CORD_LENGTH-1:0] dx, dy;
   dir_e                   dir;
   logic signed [SWIDTH-1:0] acc_score;

   assign p1 = CWIDTH'(char_at(MAX_SW'(s1_q), int'(py_q), LENGTH, CWIDTH));
   assign p2 = CWIDTH'(char_at(MAX_SW'(s2_q), int'(px_q), LENGTH, CWIDTH));
   assign f1 = CWIDTH'(char_at(MAX_SW'(s1_q), 0, LENGTH, CWIDTH));
   assign f2 = CWIDTH'(char_at(MAX_SW'(s2_q), 0, LENGTH, CWIDTH));

   assign in_ready = (state_q == S_FIRST) || (state_q == S_ERR) ||
                     ((state_q == S_RUN) && (!ov_q || out_ready));
   assign accept   = in_valid && in_ready;

   // Only unit steps toward the origin are legal; guard against wrap.
   always_comb begin
      dx  = px_q - in_x;
      dy  = py_q - in_y;
      dir = NO_DIR;
      if (in_x <= px_q && in_y <= py_q) begin
         if (dx == ONE && dy == ONE)
            dir = CORNER_DIR;
         else if (dx == '0 && dy == ONE)
            dir = TOP_DIR;
         else if (dx == ONE && dy == '0)
            dir = LEFT_DIR;
      end
   end

   always_comb begin
      state_d = state_q;
      s1_d    = s1_q;
      s2_d    = s2_q;
      px_d    = px_q;
      py_d    = py_q;
      ov_d    = ov_q;
      c1_d    = c1_q;
      c2_d    = c2_q;
      g1_d    = g1_q;
      g2_d    = g2_q;
      last_d  = last_q;
      clr     = 1'b0;
      inc_m   = 1'b0;
      inc_mm  = 1'b0;
      inc_g   = 1'b0;

      case (state_q)
         S_FIRST: begin
            if (accept) begin
               if (in_x == LASTC && in_y == LASTC) begin
                  px_d    = in_x;
                  py_d    = in_y;
                  state_d = S_RUN;
               end else begin
                  state_d = S_ERR;
               end
            end
         end
         S_RUN: begin
            if (ov_q && out_ready) ov_d = 1'b0;
            if (accept) begin
               last_d = 1'b0;
               unique case (dir)
                  CORNER_DIR: begin
                     ov_d   = 1'b1;
                     c1_d   = p1;
                     c2_d   = p2;
                     g1_d   = 1'b0;
                     g2_d   = 1'b0;
                     inc_m  = (p1 == p2);
                     inc_mm = (p1 != p2);
                  end
                  TOP_DIR: begin
                     ov_d  = 1'b1;
                     c1_d  = p1;
                     c2_d  = '0;
                     g1_d  = 1'b0;
                     g2_d  = 1'b1;
                     inc_g = 1'b1;
                  end
                  LEFT_DIR: begin
                     ov_d  = 1'b1;
                     c1_d  = '0;
                     c2_d  = p2;
                     g1_d  = 1'b1;
                     g2_d  = 1'b0;
                     inc_g = 1'b1;
                  end
                  default: begin
                     ov_d    = 1'b0;
                     state_d = S_ERR;
                  end
               endcase
               if (dir != NO_DIR) begin
                  px_d = in_x;
                  py_d = in_y;
                  if (in_x == '0 && in_y == '0) state_d = S_FLUSH;
               end
            end
         end
         S_FLUSH: begin
            if (ov_q && last_q) begin
               if (out_ready) begin
                  ov_d    = 1'b0;
                  last_d  = 1'b0;
                  state_d = S_DONE;
               end
            end else if (!ov_q || out_ready) begin
               ov_d   = 1'b1;
               c1_d   = f1;
               c2_d   = f2;
               g1_d   = 1'b0;
               g2_d   = 1'b0;
               last_d = 1'b1;
               inc_m  = (f1 == f2);
               inc_mm = (f1 != f2);
            end
         end
         S_ERR: begin
            ov_d = 1'b0;
         end
         default: ;
      endcase

      if (start) begin
         s1_d    = s1;
         s2_d    = s2;
         clr     = 1'b1;
         inc_m   = 1'b0;
         inc_mm  = 1'b0;
         inc_g   = 1'b0;
         ov_d    = 1'b0;
         last_d  = 1'b0;
         state_d = S_FIRST;
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         s1_q    <= '0;
         s2_q    <= '0;
         px_q    <= '0;
         py_q    <= '0;
         ov_q    <= 1'b0;
         c1_q    <= '0;
         c2_q    <= '0;
         g1_q    <= 1'b0;
         g2_q    <= 1'b0;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         s1_q    <= s1_d;
         s2_q    <= s2_d;
         px_q    <= px_d;
         py_q    <= py_d;
         ov_q    <= ov_d;
         c1_q    <= c1_d;
         c2_q    <= c2_d;
         g1_q    <= g1_d;
         g2_q    <= g2_d;
         last_q  <= last_d;
      end
   end

   nw_score_acc #(
      .CNT_W    (CNT_W),
      .SWIDTH   (SWIDTH),
      .MATCH    (MATCH),
      .INDEL    (INDEL),
      .MISMATCH (MISMATCH)
   ) u_acc (
      .clk    (clk),
      .reset  (reset),
      .clr    (clr),
      .inc_m  (inc_m),
      .inc_mm (inc_mm),
      .inc_g  (inc_g),
      .score  (acc_score)
   );

   assign out_valid = ov_q;
   assign out_c1    = c1_q;
   assign out_c2    = c2_q;
   assign out_gap1  = g1_q;
   assign out_gap2  = g2_q;
   assign out_last  = last_q;
   assign done      = (state_q == S_DONE);
   assign err       = (state_q == S_ERR);
   assign score     = done ? acc_score : '0;

endmodule
